// File: rtl/addsub_slice.sv
// One CHUNK-bit slice of the sequential adder/subtractor.
// Ports: a, b, cin in; s, cout (slice carry-out), cmsb (carry into top bit) out.
module addsub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s    = sum[CHUNK-1:0];
    assign cout = sum[CHUNK];
    // Carry into the top bit recovered from its sum bit; with CHUNK=1 this is cin.
    assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub, CHUNK bits per clock, valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready, a, b, m, out_valid/out_ready, s, cout, ovf, zero, neg.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $fatal(1, "addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    logic [CHUNK-1:0] sl_a;
    logic [CHUNK-1:0] sl_b;
    logic [CHUNK-1:0] sl_s;
    logic             sl_cout;
    logic             sl_cmsb;
    logic [WIDTH-1:0] s_nxt;
    logic             last;

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (c_q),
        .s    (sl_s),
        .cout (sl_cout),
        .cmsb (sl_cmsb)
    );

    // Slice select and result merge by idx, using constant part-selects.
    always_comb begin
        sl_a  = '0;
        sl_b  = '0;
        s_nxt = s_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                sl_a = a_q[i*CHUNK +: CHUNK];
                sl_b = b_q[i*CHUNK +: CHUNK];
                s_nxt[i*CHUNK +: CHUNK] = sl_s;
            end
        end
    end

    assign last = (idx == IW'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            idx    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        // Subtract as a + ~b + 1: invert b here, inject 1 as carry.
                        b_q <= b ^ {WIDTH{m}};
                        c_q <= m;
                        idx <= '0;
                    end
                end
                RUN: begin
                    s_q <= s_nxt;
                    c_q <= sl_cout;
                    idx <= idx + 1'b1;
                    if (last) begin
                        cout_q <= sl_cout;
                        ovf_q  <= sl_cout ^ sl_cmsb;
                        zero_q <= (s_nxt == '0);
                        neg_q  <= s_nxt[WIDTH-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: CHUNK=4, 1 and 16 instances with WIDTH=16.
// Table vectors per instance plus backpressure and mid-run reset sequences.
module tb_addsub_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] av;
    logic [15:0] bv;
    logic        mv;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [15:0] s_o       [3];
    logic        cout_o    [3];
    logic        ovf_o     [3];
    logic        zero_o    [3];
    logic        neg_o     [3];

    int checks;
    int failures;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        addsub_seq #(.WIDTH(16), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (av),
            .b         (bv),
            .m         (mv),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .s         (s_o[g]),
            .cout      (cout_o[g]),
            .ovf       (ovf_o[g]),
            .zero      (zero_o[g]),
            .neg       (neg_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs [8];
    int   lats [3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int d, input vec_t v, input int lat);
        int cyc;
        cyc = 0;
        while (!in_ready[d] && cyc < 100) begin
            step();
            cyc++;
        end
        chk("in_ready_before", int'(in_ready[d]), 1);
        av = v.a;
        bv = v.b;
        mv = v.m;
        in_valid[d] = 1'b1;
        step();
        in_valid[d] = 1'b0;
        av = 16'hDEAD;
        bv = 16'hBEEF;
        cyc = 0;
        while (!out_valid[d] && cyc < 100) begin
            step();
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("s", int'(s_o[d]), int'(v.s));
        chk("cout", int'(cout_o[d]), int'(v.c));
        chk("ovf", int'(ovf_o[d]), int'(v.o));
        chk("zero", int'(zero_o[d]), int'(v.z));
        chk("neg", int'(neg_o[d]), int'(v.n));
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
        chk("in_ready_after", int'(in_ready[d]), 1);
        chk("out_valid_after", int'(out_valid[d]), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        av = '0;
        bv = '0;
        mv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end
        lats[0] = 4;
        lats[1] = 16;
        lats[2] = 1;

        //          a         b         m     s         c     o     z     n
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0008, 16'h000A, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'h000A, 16'h0008, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};

        #12;
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", int'(in_ready[d]), 1);
            chk("rst_out_valid", int'(out_valid[d]), 0);
            chk("rst_s", int'(s_o[d]), 0);
            chk("rst_flags", int'({cout_o[d], ovf_o[d], zero_o[d], neg_o[d]}), 0);
        end
        rst_n = 1'b1;
        step();

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin
                op(d, vecs[i], lats[d]);
            end
        end

        // Backpressure: hold DONE, offer new input that must be ignored.
        av = 16'h1234;
        bv = 16'h4321;
        mv = 1'b0;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bp_valid", int'(out_valid[0]), 1);
        av = 16'h0001;
        bv = 16'h0001;
        mv = 1'b1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", int'(out_valid[0]), 1);
            chk("bp_in_ready", int'(in_ready[0]), 0);
            chk("bp_s", int'(s_o[0]), 16'h5555);
            chk("bp_flags", int'({cout_o[0], ovf_o[0], zero_o[0], neg_o[0]}), 0);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
        chk("bp_idle_ready", int'(in_ready[0]), 1);
        chk("bp_idle_valid", int'(out_valid[0]), 0);
        step();
        chk("bp_not_accepted", int'(in_ready[0]), 1);

        // Reset two cycles into RUN.
        av = 16'hFFFF;
        bv = 16'h0001;
        mv = 1'b0;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s", int'(s_o[0]), 0);
        chk("mid_rst_in_ready", int'(in_ready[0]), 1);
        chk("mid_rst_out_valid", int'(out_valid[0]), 0);
        chk("mid_rst_flags", int'({cout_o[0], ovf_o[0], zero_o[0], neg_o[0]}), 0);
        #3;
        rst_n = 1'b1;
        step();
        op(0, '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0}, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
